// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of a combinational 8-bit ALU. The FIFO head drives the ALU,
// and the ALU result is captured in an output register that is drained in push order.
module alu_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [2:0]       in_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] count
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holding valid keeps its payload stable, ready never depends on valid.
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [7:0]       mem_a_q  [DEPTH];
  logic [7:0]       mem_a_d  [DEPTH];
  logic [7:0]       mem_b_q  [DEPTH];
  logic [7:0]       mem_b_d  [DEPTH];
  logic [2:0]       mem_op_q [DEPTH];
  logic [2:0]       mem_op_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_result_q, out_result_d;
  logic [2:0]       out_op_q, out_op_d;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty      = (count_q == '0);
  assign in_ready   = (count_q != FULL);
  assign push       = in_valid && in_ready;
  assign pop        = !empty && (!out_valid_q || out_ready);
  assign count      = count_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;

  always_comb begin
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    alu_op = 3'b000;
    if (!empty) begin
      alu_a  = mem_a_q[rd_ptr_q];
      alu_b  = mem_b_q[rd_ptr_q];
      alu_op = mem_op_q[rd_ptr_q];
    end
  end

  always_comb begin
    mem_a_d      = mem_a_q;
    mem_b_d      = mem_b_q;
    mem_op_d     = mem_op_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;
    if (push) begin
      mem_a_d[wr_ptr_q]  = in_a;
      mem_b_d[wr_ptr_q]  = in_b;
      mem_op_d[wr_ptr_q] = in_op;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    // The pop reads the old head, so an entry written this cycle is never bypassed.
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      out_valid_d  = 1'b1;
      out_result_d = alu_o;
      out_op_d     = alu_op;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= 8'h00;
      out_op_q     <= 3'b000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_a_q  <= mem_a_d;
    mem_b_q  <= mem_b_d;
    mem_op_q <= mem_op_d;
  end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomised and directed bench for alu_cmd_queue: queue-based reference model,
// result scoreboard and a behavioural ALU closing the loop on alu_o.
module tb_alu_cmd_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = 8'h00;
  logic [7:0]       in_b = 8'h00;
  logic [2:0]       in_op = 3'b000;
  logic [7:0]       alu_a, alu_b, alu_o;
  logic [2:0]       alu_op;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_result;
  logic [2:0]       out_op;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [18:0] m_fifo[$];
  logic        m_ov = 1'b0;
  logic [7:0]  m_res = 8'h00;
  logic [2:0]  m_op = 3'b000;

  alu_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b;
      3'd3:    return a >> b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return (a == b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  always_comb alu_o = alu_ref(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command queue plus one result slot, advanced per clock edge.
  always @(posedge clk) begin
    logic do_pop, do_push;
    logic [18:0] c;
    if (reset) begin
      m_fifo.delete();
      exp_q.delete();
      m_ov  = 1'b0;
      m_res = 8'h00;
      m_op  = 3'b000;
    end else begin
      do_pop  = (m_fifo.size() != 0) && (!m_ov || out_ready);
      do_push = in_valid && (m_fifo.size() != DEPTH);
      if (do_pop) begin
        c     = m_fifo.pop_front();
        m_ov  = 1'b1;
        m_res = alu_ref(c[15:8], c[7:0], c[18:16]);
        m_op  = c[18:16];
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (do_push) begin
        m_fifo.push_back({in_op, in_a, in_b});
        exp_q.push_back({in_op, alu_ref(in_a, in_b, in_op)});
      end
    end
  end

  // Monitor: cycle-level comparison plus in-order scoreboard on accepted results.
  always @(negedge clk) begin
    logic [10:0] e;
    chk("count", count, m_fifo.size());
    chk("in_ready", in_ready, m_fifo.size() != DEPTH);
    chk("out_valid", out_valid, m_ov);
    chk("out_result_reg", out_result, m_res);
    chk("out_op_reg", out_op, m_op);
    if (m_fifo.size() != 0) begin
      chk("alu_drive", {alu_op, alu_a, alu_b}, m_fifo[0]);
    end else begin
      chk("alu_drive_empty", {alu_op, alu_a, alu_b}, 19'h0);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", {out_op, out_result}, e);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) chk("push_timeout", 1, 0);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drive_cycles(input int n, input bit rnd);
    bit acc = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (acc || !in_valid) begin
        in_a = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 9));
        in_op = 3'($urandom_range(0, 7));
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [7:0] held_r;
    logic [2:0] held_o;

    tick(2);
    reset = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_out_valid", out_valid, 0);

    // Single command, latency 1, no bypass.
    out_ready = 1'b1;
    push_cmd(8'h0F, 8'h01, 3'd0);
    chk("single_no_bypass", out_valid, 0);
    tick(1);
    chk("single_valid", out_valid, 1);
    chk("single_result", out_result, 8'h10);
    chk("single_count", count, 0);
    tick(1);
    chk("single_drop", out_valid, 0);

    // Backpressure fill: DEPTH+1 accepted.
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_b = 8'h01;
    in_op = 3'd1;
    for (int i = 0; i < 8; i++) begin
      in_a = 8'(5 + acc);
      if (in_ready) acc++;
      tick(1);
    end
    in_valid = 1'b0;
    chk("fill_accepted", acc, 5);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    chk("fill_result", out_result, 8'h04);
    out_ready = 1'b1;
    tick(6);
    chk("fill_drained", out_valid, 0);

    // Mixed opcodes at full rate.
    push_cmd(8'h01, 8'd3, 3'd2);
    push_cmd(8'h80, 8'd7, 3'd3);
    push_cmd(8'hF0, 8'h3C, 3'd4);
    push_cmd(8'h0F, 8'hF0, 3'd5);
    push_cmd(8'hFF, 8'h0F, 3'd6);
    push_cmd(8'h5A, 8'h5A, 3'd7);
    tick(3);

    // Simultaneous push and pop at full, then wrap-around.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'(i * 17), 8'(i), 3'(i));
    chk("full_count", count, 4);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick(1);
    chk("full_pop_only", count, 3);
    chk("full_ready_rises", in_ready, 1);
    tick(1);
    chk("full_push_pop", count, 3);
    drive_cycles(12, 1'b0);
    tick(6);

    // Output hold under stall while pushes continue.
    out_ready = 1'b0;
    push_cmd(8'h33, 8'h11, 3'd6);
    tick(1);
    held_r = out_result;
    held_o = out_op;
    chk("hold_valid", out_valid, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("hold_result", out_result, held_r);
      chk("hold_op", out_op, held_o);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(7);

    // Reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(8'(i + 1), 8'h02, 3'd0);
    chk("pre_reset_count", count, 3);
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_reset_count", count, 0);
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_result", out_result, 0);
    chk("mid_reset_ready", in_ready, 1);
    chk("mid_reset_alu", {alu_op, alu_a, alu_b}, 0);
    out_ready = 1'b1;
    push_cmd(8'h02, 8'h03, 3'd0);
    tick(1);
    chk("post_reset_result", out_result, 8'h05);
    tick(2);

    // Random traffic, then drain.
    drive_cycles(400, 1'b1);
    out_ready = 1'b1;
    tick(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Upstream feeder for the team's 8-bit combinational ALU (inputs a, b, op; output alu_o).
- Buffers ALU commands arriving on a valid/ready interface in a small FIFO.
- Presents the FIFO head to the ALU, registers the ALU result, and returns it in order on a valid/ready output interface.
- Decouples the command producer from the result consumer so that backpressure never stalls the producer until the queue fills.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of the occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  queue can accept a command.
- in_a  input  8  operand A.
- in_b  input  8  operand B (also the shift amount for SLL/LSR).
- in_op  input  3  ALU opcode.
- alu_a  output  8  to ALU a.
- alu_b  output  8  to ALU b.
- alu_op  output  3  to ALU op.
- alu_o  input  8  ALU result, combinational from alu_a/alu_b/alu_op.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  8  registered ALU result.
- out_op  output  3  opcode that produced out_result.
- count  output  CNT_W  FIFO occupancy, 0..DEPTH; excludes the output register.

Behaviour:
- Clocking and reset:
  - One clock, clk; all state updates on the rising edge.
  - Reset is synchronous and active-high on reset; it takes priority over every other event.
  - On reset: FIFO emptied (rd/wr pointers 0, count 0), out_valid 0, out_result 0x00, out_op 3'b000.
  - Reset asserted mid-operation discards all queued entries and any pending result, including one with out_valid high.
- Opcode encoding is fixed: 000 ADD, 001 SUB, 010 SLL, 011 LSR, 100 AND, 101 OR, 110 XOR, 111 EQL.
  - The block passes opcodes through unmodified and does not validate them.
- Push:
  - A push occurs when in_valid && in_ready.
  - in_ready = (count != DEPTH).
  - in_ready is registered state only; it has no combinational dependence on out_ready or on a same-cycle pop.
  - in_a, in_b and in_op are ignored when in_valid is 0.
- ALU drive:
  - When count != 0, alu_a, alu_b and alu_op equal the head entry, combinationally from the FIFO storage.
  - When the FIFO is empty they drive 0x00, 0x00, 3'b000.
- Pop/issue:
  - pop = (count != 0) && (!out_valid || out_ready).
  - On pop: out_result <= alu_o; out_op <= head op; out_valid <= 1; read pointer advances.
- Output drain:
  - If out_valid && out_ready and there is no pop, out_valid <= 0.
  - out_result and out_op hold while out_valid && !out_ready.
  - The output register never changes while it holds an unaccepted result.
- Latency:
  - A command pushed at edge N is at the head at earliest during cycle N+1 (FIFO previously empty).
  - It is popped at edge N+1, so out_valid is high from edge N+1.
  - Minimum push-to-out_valid latency is 1 cycle, with no same-cycle bypass.
  - Sustained throughput is 1 result per cycle when out_ready is held high.
- Simultaneous push and pop:
  - Legal whenever in_ready is 1; count is unchanged.
  - When the FIFO is empty, the pushed entry is not popped in the same cycle (no bypass).
- Count:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Pointers:
  - log2(DEPTH)-bit read/write pointers, wrapping modulo DEPTH.
  - Full/empty are derived from count.
- Ordering: results emerge in strict push order; no reordering and no drops.
- Capacity under a stalled consumer: DEPTH entries in the FIFO plus 1 in the output register, i.e. DEPTH+1 commands accepted before in_ready falls.
- Arithmetic width: the ALU result is 8 bits. No carry or flags are captured; width is set by alu_o.

Test Plan:
- Single command: after reset, push ADD a=0x0F b=0x01 at edge N with out_ready=1 -> out_valid high from edge N+1 for one cycle, out_result=0x10, out_op=000, count back to 0.
- Backpressure fill: out_ready=0, push SUB 0x05-0x01, 0x06-0x01, ..., 0x0A-0x01 continuously -> exactly 5 accepted, in_ready falls after the 5th, count=4, out_result=0x04. Then raise out_ready -> results 0x04,0x05,0x06,0x07,0x08 on consecutive cycles, in order, then out_valid=0.
- Mixed ops at full rate: push SLL 0x01,3; LSR 0x80,7; AND 0xF0,0x3C; OR 0x0F,0xF0; XOR 0xFF,0x0F; EQL 0x5A,0x5A with out_ready=1 -> 0x08,0x01,0x30,0xFF,0xF0,0x01 back-to-back, count never >1.
- Simultaneous push/pop at full: fill to count=4 with out_valid held, then set in_valid=1 and out_ready=1 -> first edge pops only (count=3, in_ready rises), next edge push+pop keeps count=3. Wrap-around exercised over more than 8 pushes with no corruption.
- Reset mid-operation: with count=3 and out_valid=1, assert reset for one cycle -> next cycle count=0, out_valid=0, out_result=0x00, in_ready=1, alu_a/alu_b/alu_op=0. A post-reset push of ADD 0x02,0x03 yields 0x05.
- Output hold: out_valid=1 with out_ready=0 for 10 cycles while pushes continue -> out_result/out_op stable throughout and the FIFO head is not consumed.
